// File: rtl/prism_comm_fifo_if.sv
// rtl/prism_comm_fifo_if.sv - producer/consumer/control signal bundle for the comm byte FIFO
interface prism_comm_fifo_if #(
  parameter int AW    = 3,
  parameter int WIDTH = 8
);
  logic             clr;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic [AW:0]      level;
  logic             empty;
  logic             full;
  logic [AW:0]      thresh;
  logic             overflow;
  logic             underflow;
  logic             flag_clr;
  logic             irq;

  modport master (
    output clr, push, push_data, pop, thresh, flag_clr,
    input  pop_data, level, empty, full, overflow, underflow, irq
  );

  modport slave (
    input  clr, push, push_data, pop, thresh, flag_clr,
    output pop_data, level, empty, full, overflow, underflow, irq
  );
endinterface

// File: rtl/prism_comm_fifo.sv
// rtl/prism_comm_fifo.sv - receive byte FIFO between the comm shift register and CPU reads
module prism_comm_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  prism_comm_fifo_if.slave   bus
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             irq_q, irq_d;
  logic             empty, full;
  logic             pop_acc, push_acc, wr_en;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    pop_acc  = bus.pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push_acc = bus.push && (!full || pop_acc);
    wr_en    = push_acc && !bus.clr;
    if (bus.clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_acc && !pop_acc)      level_d = level_q + 1'b1;
      else if (pop_acc && !push_acc) level_d = level_q - 1'b1;
      if (bus.flag_clr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      // New events win over a same-cycle flag clear.
      if (bus.push && !push_acc) ovf_d = 1'b1;
      if (bus.pop && empty)      unf_d = 1'b1;
    end
    irq_d = ((bus.thresh != '0) && (level_d >= bus.thresh)) || ovf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage is not reset; pop_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.push_data;
  end

  assign bus.pop_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.level     = level_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.irq       = irq_q;
endmodule
